// File: rtl/mem_router_pkg.sv
// Shared types and constants for the CPU-to-slave memory router.
package mem_router_pkg;

    localparam int SEL_WIDTH  = 4;
    localparam int WORD_BYTES = 4;
    localparam int MAX_SLAVES = 1 << SEL_WIDTH;

    // One entry per in-flight read: where its data will come from.
    typedef struct packed {
        logic                 mapped;
        logic [SEL_WIDTH-1:0] sel;
    } read_tag_t;

    // One-hot over the full select space, so callers never index past NUM_SLAVES.
    function automatic logic [MAX_SLAVES-1:0] sel_onehot(input logic [SEL_WIDTH-1:0] sel);
        return MAX_SLAVES'(1) << sel;
    endfunction

endpackage

// File: rtl/read_tag_fifo.sv
// Synchronous FIFO of read tags; keeps read returns in request order.
module read_tag_fifo
    import mem_router_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic      clk,
    input  logic      reset,
    input  logic      push,
    input  read_tag_t push_tag,
    input  logic      pop,
    output read_tag_t head,
    output logic      empty,
    output logic      full
);

    localparam int            AW      = $clog2(DEPTH);
    localparam logic [AW:0]   PTR_ONE = 1;

    read_tag_t   mem [DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;

    // Pointer update; the extra top bit distinguishes full from empty.
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    // Tag storage write.
    always_ff @(posedge clk) begin
        // NOTE: storage is not reset; the pointers alone decide which entries are live.
        if (push) mem[wr_ptr[AW-1:0]] <= push_tag;
    end

    assign head  = mem[rd_ptr[AW-1:0]];
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/mem_router.sv
// Routes one CPU memory port to NUM_SLAVES slaves by the high address bits,
// returning read data in request order through a tag FIFO.
module mem_router
    import mem_router_pkg::*;
#(
    parameter int          NUM_SLAVES      = 4,
    parameter int          SEL_LSB         = 28,
    parameter int          MAX_OUTSTANDING = 4,
    parameter logic [31:0] UNMAPPED_DATA   = 32'h0000_0000
) (
    input  logic                    clk,
    input  logic                    reset,
    output logic                    ready,
    input  logic [31:0]             addr,
    input  logic [31:0]             write_data,
    input  logic [WORD_BYTES-1:0]   byte_enable,
    input  logic                    write_req,
    input  logic                    read_req,
    output logic [31:0]             read_data,
    output logic                    read_data_valid,
    output logic                    error,
    output logic [SEL_LSB-3:0]      slave_addr,
    output logic [31:0]             slave_write_data,
    output logic [WORD_BYTES-1:0]   slave_byte_enable,
    output logic [NUM_SLAVES-1:0]   slave_write_req,
    output logic [NUM_SLAVES-1:0]   slave_read_req,
    input  logic [NUM_SLAVES-1:0]   slave_ready,
    input  logic [32*NUM_SLAVES-1:0] slave_read_data,
    input  logic [NUM_SLAVES-1:0]   slave_read_data_valid
);

    localparam int DATA_PAD_W = 32 * MAX_SLAVES;

    logic [SEL_WIDTH-1:0]  sel;
    logic                  mapped;
    logic [MAX_SLAVES-1:0] ready_pad;
    logic [MAX_SLAVES-1:0] valid_pad;
    logic [DATA_PAD_W-1:0] data_pad;
    logic [MAX_SLAVES-1:0] req_onehot;
    logic [MAX_SLAVES-1:0] expected_valid;
    logic                  conflict;
    logic                  accept_write;
    logic                  accept_read;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  pop_mapped;
    logic                  pop_unmapped;
    logic                  pop;
    logic                  stray_valid;
    read_tag_t             head;
    read_tag_t             push_tag;
    logic [31:0]           unused_addr;

    // Slave-side vectors widened to the full select space so an unmapped
    // select or tag can never index out of range.
    assign ready_pad = MAX_SLAVES'(slave_ready);
    assign valid_pad = MAX_SLAVES'(slave_read_data_valid);
    assign data_pad  = DATA_PAD_W'(slave_read_data);

    // Collects address bits that take no part in routing.
    assign unused_addr = addr;

    // ---------------- request path (combinational) ----------------
    assign sel    = addr[SEL_LSB +: SEL_WIDTH];
    assign mapped = ({1'b0, sel} < (SEL_WIDTH+1)'(NUM_SLAVES));

    // Depends only on registered FIFO state and the decoded target, never on the request itself.
    assign ready = !fifo_full && (!mapped || ready_pad[sel]);

    // Simultaneous read and write is a protocol violation; neither goes out.
    assign conflict     = write_req && read_req;
    assign accept_write = write_req && !read_req && ready && mapped;
    assign accept_read  = read_req && !write_req && ready;

    assign req_onehot      = sel_onehot(sel);
    assign slave_write_req = NUM_SLAVES'(req_onehot & {MAX_SLAVES{accept_write}});
    assign slave_read_req  = NUM_SLAVES'(req_onehot & {MAX_SLAVES{accept_read && mapped}});

    assign slave_addr        = addr[SEL_LSB-1:2];
    assign slave_write_data  = write_data;
    assign slave_byte_enable = byte_enable;

    // Unmapped reads are tracked too, so their filler data returns in order.
    assign push_tag = '{mapped: mapped, sel: sel};

    read_tag_fifo #(
        .DEPTH (MAX_OUTSTANDING)
    ) u_tag_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (accept_read),
        .push_tag (push_tag),
        .pop      (pop),
        .head     (head),
        .empty    (fifo_empty),
        .full     (fifo_full)
    );

    // ---------------- return path ----------------
    // Only the head's slave may respond; any other valid is a violation.
    assign expected_valid = (!fifo_empty && head.mapped) ? sel_onehot(head.sel) : '0;
    assign pop_mapped     = |(valid_pad & expected_valid);
    assign pop_unmapped   = !fifo_empty && !head.mapped;
    assign pop            = pop_mapped || pop_unmapped;
    assign stray_valid    = |(valid_pad & ~expected_valid);

    // Registered read return and sticky error flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            read_data       <= '0;
            read_data_valid <= 1'b0;
            error           <= 1'b0;
        end else begin
            read_data_valid <= pop;
            if (pop) begin
                read_data <= head.mapped ? data_pad[32*head.sel +: 32] : UNMAPPED_DATA;
            end
            if (conflict || stray_valid) error <= 1'b1;
        end
    end

endmodule

// File: tb/tb_mem_router.sv
// Self-checking bench for mem_router: a queue-based reference model checked
// every cycle, directed scenarios with literal expectations, and a random run.
`timescale 1ns/1ps
module tb_mem_router;

    localparam int          NS    = 4;
    localparam int          DEPTH = 4;
    localparam logic [31:0] UNMAP = 32'h0000_0000;

    logic           clk = 1'b0;
    logic           reset;
    logic           ready;
    logic [31:0]    addr;
    logic [31:0]    write_data;
    logic [3:0]     byte_enable;
    logic           write_req;
    logic           read_req;
    logic [31:0]    read_data;
    logic           read_data_valid;
    logic           error;
    logic [25:0]    slave_addr;
    logic [31:0]    slave_write_data;
    logic [3:0]     slave_byte_enable;
    logic [NS-1:0]  slave_write_req;
    logic [NS-1:0]  slave_read_req;
    logic [NS-1:0]  slave_ready;
    logic [32*NS-1:0] slave_read_data;
    logic [NS-1:0]  slave_read_data_valid;

    mem_router #(
        .NUM_SLAVES      (NS),
        .SEL_LSB         (28),
        .MAX_OUTSTANDING (DEPTH),
        .UNMAPPED_DATA   (UNMAP)
    ) dut (
        .clk                   (clk),
        .reset                 (reset),
        .ready                 (ready),
        .addr                  (addr),
        .write_data            (write_data),
        .byte_enable           (byte_enable),
        .write_req             (write_req),
        .read_req              (read_req),
        .read_data             (read_data),
        .read_data_valid       (read_data_valid),
        .error                 (error),
        .slave_addr            (slave_addr),
        .slave_write_data      (slave_write_data),
        .slave_byte_enable     (slave_byte_enable),
        .slave_write_req       (slave_write_req),
        .slave_read_req        (slave_read_req),
        .slave_ready           (slave_ready),
        .slave_read_data       (slave_read_data),
        .slave_read_data_valid (slave_read_data_valid)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct packed { bit mapped; bit [3:0] sel; } tag_t;
    tag_t        mq[$];
    bit          mdl_on = 0;
    bit          e_valid;
    logic [31:0] e_data;
    bit          e_err;

    // Compare DUT against the model mid-cycle, then advance the model across the coming edge.
    always @(negedge clk) begin
        int unsigned s;
        bit          m;
        bit          e_ready;
        bit          conf;
        bit [3:0]    exp_wr;
        bit [3:0]    exp_rd;
        bit [3:0]    allowed;
        s       = addr[31:28];
        m       = (s < NS);
        e_ready = (mq.size() < DEPTH) && (m ? slave_ready[s] : 1'b1);
        conf    = write_req && read_req;
        exp_wr  = '0;
        exp_rd  = '0;
        if (m && e_ready && !conf) begin
            if (write_req) exp_wr[s] = 1'b1;
            if (read_req)  exp_rd[s] = 1'b1;
        end
        if (mdl_on) begin
            check("ready",      ready, e_ready);
            check("wr_strobe",  slave_write_req, exp_wr);
            check("rd_strobe",  slave_read_req, exp_rd);
            check("slave_addr", slave_addr, addr[27:2]);
            check("slave_wdata", slave_write_data, write_data);
            check("slave_be",   slave_byte_enable, byte_enable);
            check("rd_valid",   read_data_valid, e_valid);
            check("rd_data",    read_data, e_data);
            check("error",      error, e_err);
        end
        if (reset) begin
            mq.delete();
            e_valid = 0;
            e_data  = '0;
            e_err   = 0;
            mdl_on  = 1;
        end else begin
            e_valid = 0;
            allowed = '0;
            if (mq.size() > 0) begin
                if (!mq[0].mapped) begin
                    e_valid = 1;
                    e_data  = UNMAP;
                    void'(mq.pop_front());
                end else begin
                    allowed[mq[0].sel] = 1'b1;
                    if (slave_read_data_valid[mq[0].sel]) begin
                        e_valid = 1;
                        e_data  = slave_read_data[32*mq[0].sel +: 32];
                        void'(mq.pop_front());
                    end
                end
            end
            if ((slave_read_data_valid & ~allowed) != '0) e_err = 1;
            if (conf) e_err = 1;
            if (read_req && !write_req && e_ready) mq.push_back('{mapped: m, sel: 4'(s)});
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        write_req             = 1'b0;
        read_req              = 1'b0;
        addr                  = '0;
        write_data            = '0;
        byte_enable           = '0;
        slave_read_data_valid = '0;
        slave_read_data       = '0;
    endtask

    task automatic rd(input logic [31:0] a);
        read_req = 1'b1;
        addr     = a;
    endtask

    task automatic sv(input int s, input logic [31:0] d);
        slave_read_data_valid[s]   = 1'b1;
        slave_read_data[32*s +: 32] = d;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset       = 1'b1;
        slave_ready = 4'hF;
        idle();
        next_cycle();
        next_cycle();
        reset = 1'b0;
        @(negedge clk);
        check("rst_valid", read_data_valid, 1'b0);
        check("rst_error", error, 1'b0);
        check("rst_ready", ready, 1'b1);
        check("rst_data",  read_data, 32'h0);

        // Mapped write to slave 1.
        next_cycle(); idle();
        write_req = 1'b1; addr = 32'h1000_0004; write_data = 32'hA5A5_0001; byte_enable = 4'b0011;
        @(negedge clk);
        check("wr_strobe_lit", slave_write_req, 4'b0010);
        check("wr_addr_lit",   slave_addr, 26'd1);
        check("wr_ready_lit",  ready, 1'b1);
        check("wr_no_read",    slave_read_req, 4'b0000);

        // Slave 0 answers before slave 2: violation.
        next_cycle(); idle(); rd(32'h2000_0010);
        next_cycle(); idle(); rd(32'h0000_0020);
        next_cycle(); idle(); sv(0, 32'h1111_0000);
        next_cycle(); idle();
        @(negedge clk);
        check("ooo_error", error, 1'b1);
        next_cycle(); idle(); reset = 1'b1;
        next_cycle(); idle(); reset = 1'b0;

        // Same two reads with in-order returns.
        next_cycle(); idle(); rd(32'h2000_0010);
        next_cycle(); idle(); rd(32'h0000_0020);
        repeat (3) begin next_cycle(); idle(); end
        next_cycle(); idle(); sv(2, 32'hCAFE_0002);
        next_cycle(); idle(); sv(0, 32'hBEEF_0000);
        @(negedge clk);
        check("ord_data0",  read_data, 32'hCAFE_0002);
        check("ord_valid0", read_data_valid, 1'b1);
        next_cycle(); idle();
        @(negedge clk);
        check("ord_data1",  read_data, 32'hBEEF_0000);
        check("ord_valid1", read_data_valid, 1'b1);
        next_cycle(); idle();
        @(negedge clk);
        check("ord_idle_valid", read_data_valid, 1'b0);
        check("ord_hold_data",  read_data, 32'hBEEF_0000);
        check("ord_no_error",   error, 1'b0);

        // Fill the FIFO with reads to a silent slave.
        for (int i = 0; i < DEPTH; i++) begin
            next_cycle(); idle(); rd(32'h3000_0000 + 32'(i * 4));
        end
        next_cycle(); idle(); rd(32'h3000_0040);
        @(negedge clk);
        check("full_ready", ready, 1'b0);
        check("full_no_strobe", slave_read_req, 4'b0000);
        next_cycle(); idle(); rd(32'h3000_0040); sv(3, 32'h3333_0000);
        @(negedge clk);
        check("full_pop_ready", ready, 1'b0);
        next_cycle(); idle(); rd(32'h3000_0040);
        @(negedge clk);
        check("after_pop_ready",  ready, 1'b1);
        check("after_pop_strobe", slave_read_req, 4'b1000);
        check("after_pop_data",   read_data, 32'h3333_0000);
        for (int i = 0; i < DEPTH; i++) begin
            next_cycle(); idle(); sv(3, 32'h3333_0001 + 32'(i));
        end
        next_cycle(); idle();

        // Unmapped read and write.
        next_cycle(); idle(); rd(32'h5000_0000);
        @(negedge clk);
        check("unm_no_strobe", slave_read_req, 4'b0000);
        check("unm_ready", ready, 1'b1);
        next_cycle(); idle();
        next_cycle(); idle();
        @(negedge clk);
        check("unm_data",  read_data, 32'h0000_0000);
        check("unm_valid", read_data_valid, 1'b1);
        next_cycle(); idle(); write_req = 1'b1; addr = 32'h5000_0000; write_data = 32'h1234_0000;
        @(negedge clk);
        check("unm_wr_strobe", slave_write_req, 4'b0000);
        next_cycle(); idle();
        @(negedge clk);
        check("unm_wr_error", error, 1'b0);

        // Conflict, then reset with reads outstanding.
        next_cycle(); idle(); write_req = 1'b1; read_req = 1'b1; addr = 32'h1000_0000;
        @(negedge clk);
        check("conf_wr", slave_write_req, 4'b0000);
        check("conf_rd", slave_read_req, 4'b0000);
        for (int i = 0; i < 3; i++) begin
            next_cycle(); idle(); rd(32'h1000_0100 + 32'(i * 4));
        end
        next_cycle(); idle();
        @(negedge clk);
        check("conf_error", error, 1'b1);
        next_cycle(); idle(); reset = 1'b1;
        next_cycle(); idle(); reset = 1'b0;
        @(negedge clk);
        check("rst2_valid", read_data_valid, 1'b0);
        check("rst2_error", error, 1'b0);
        check("rst2_ready", ready, 1'b1);
        next_cycle(); idle(); rd(32'h1000_0200);
        next_cycle(); idle(); sv(1, 32'h1234_5678);
        next_cycle(); idle();
        @(negedge clk);
        check("fresh_data",  read_data, 32'h1234_5678);
        check("fresh_valid", read_data_valid, 1'b1);

        // Busy slave 1 stalls only requests addressed to it.
        next_cycle(); idle(); slave_ready = 4'b1101; rd(32'h1000_0000);
        @(negedge clk);
        check("busy_ready", ready, 1'b0);
        check("busy_strobe", slave_read_req, 4'b0000);
        next_cycle(); idle(); rd(32'h0000_0000);
        @(negedge clk);
        check("other_ready", ready, 1'b1);
        check("other_strobe", slave_read_req, 4'b0001);
        next_cycle(); idle(); slave_ready = 4'hF; sv(0, 32'h0F0F_0F0F);
        next_cycle(); idle();

        // Random traffic with an in-order responder driven from the model queue.
        next_cycle(); idle(); reset = 1'b1;
        next_cycle(); idle(); reset = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            int unsigned r;
            int unsigned s;
            next_cycle(); idle();
            r = $urandom_range(0, 3);
            s = ($urandom_range(0, 9) == 0) ? 15 : $urandom_range(0, 5);
            addr = {4'(s), 26'($urandom), 2'b00};
            slave_ready = 4'($urandom) | 4'($urandom);
            slave_read_data = {$urandom(), $urandom(), $urandom(), $urandom()};
            if (r == 1 || r == 3) begin
                read_req = 1'b1;
            end else if (r == 2) begin
                write_req   = 1'b1;
                write_data  = $urandom();
                byte_enable = 4'($urandom);
            end
            if (mq.size() > 0 && mq[0].mapped && $urandom_range(0, 2) == 0)
                sv(int'(mq[0].sel), $urandom());
        end
        slave_ready = 4'hF;
        for (int k = 0; k < 200 && mq.size() > 0; k++) begin
            next_cycle(); idle();
            if (mq.size() > 0 && mq[0].mapped) sv(int'(mq[0].sel), $urandom());
        end
        next_cycle(); idle();
        @(negedge clk);
        check("drain_ready", ready, 1'b1);
        check("drain_no_error", error, 1'b0);

        // Valid while the FIFO is empty.
        next_cycle(); idle(); sv(2, 32'hDEAD_0002);
        next_cycle(); idle();
        @(negedge clk);
        check("stray_error", error, 1'b1);
        check("stray_no_valid", read_data_valid, 1'b0);

        next_cycle();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_router.md
Name: mem_router

Overview:
- Parametrised successor to the fixed two-target memory mapper: routes one CPU-side memory port to NUM_SLAVES slave ports.
- Decodes the target slave from the high address bits.
- Tracks up to MAX_OUTSTANDING in-flight reads in a FIFO, so read data returns to the CPU in request order even when slaves have different latencies.
- Sits between the cpu and the peripheral interfaces (program ROM, LEDs, future UART/RAM).

Parameters:
- NUM_SLAVES, 4: number of slave ports; legal range 1..16.
- SEL_LSB, 28: bit position of the slave-select field. Field is addr[SEL_LSB+3:SEL_LSB].
- MAX_OUTSTANDING, 4: read-tracking FIFO depth; must be a power of two, ≥ 2.
- UNMAPPED_DATA, 32'h0000_0000: read data returned for unmapped addresses.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- ready  out  1  request accepted this cycle if write_req or read_req is high.
- addr  in  32  byte address.
- write_data  in  32  write data.
- byte_enable  in  4  byte lanes for writes.
- write_req  in  1  write request.
- read_req  in  1  read request.
- read_data  out  32  returned read data.
- read_data_valid  out  1  read_data is valid this cycle.
- error  out  1  sticky protocol-violation flag.
- slave_addr  out  SEL_LSB-2  word address addr[SEL_LSB-1:2], broadcast to all slaves.
- slave_write_data  out  32  broadcast write data.
- slave_byte_enable  out  4  broadcast byte enables.
- slave_write_req  out  NUM_SLAVES  per-slave write strobe.
- slave_read_req  out  NUM_SLAVES  per-slave read strobe.
- slave_ready  in  NUM_SLAVES  per-slave ready.
- slave_read_data  in  32*NUM_SLAVES  flattened; slave i occupies bits [32i+31:32i].
- slave_read_data_valid  in  NUM_SLAVES  per-slave valid.

Behaviour:
- Decode: sel = addr[SEL_LSB+3:SEL_LSB]. mapped = (sel < NUM_SLAVES).
- Request path is combinational (zero added latency):
  - slave_write_req[sel] = write_req & mapped & ready.
  - slave_read_req[sel] = read_req & mapped & ready.
  - All other strobes are 0.
- ready = !fifo_full & (!mapped | slave_ready[sel]).
  - ready is independent of whether a request is present.
  - When fifo_full, ready = 0 for writes as well (keeps ordering simple).
- write_req and read_req both high in the same cycle sets error; neither request is forwarded.
- Accepted read: push an entry {mapped, sel} into the FIFO.
- Accepted write: nothing is tracked.
  - Unmapped writes are dropped silently.
- Return path uses the FIFO head entry (when FIFO is non-empty):
  - Mapped head: pop when slave_read_data_valid[head.sel] = 1. The registered outputs then give read_data = that slave's data and read_data_valid = 1 on the next cycle.
  - Unmapped head: pop on the first cycle it is at the head. Next cycle read_data = UNMAPPED_DATA, read_data_valid = 1.
- Latency: CPU sees read data one cycle after the slave's valid; minimum two cycles from request to data.
- Push and pop in the same cycle are both honoured; count is unchanged.
- Full with a pop in progress: ready is still 0 that cycle (ready is derived from registered count only).
- A slave_read_data_valid bit that does not match the head (including any valid while FIFO is empty) sets error. The data is ignored and the FIFO is unchanged.
- error stays set until reset.
- Reset (synchronous) clears FIFO pointers and count, error, read_data_valid, and read_data (to 0).
  - In-flight reads are forgotten.
  - Slave responses arriving after reset set error; system reset is expected to reset the slaves too.
- read_data_valid is 0 in every cycle with no pop in the preceding cycle.
- read_data holds its last value when not valid.

Decomposition:
- Package mem_router_pkg:
  - typedef read_tag_t {logic mapped; logic [3:0] sel;}.
  - Constants SEL_WIDTH = 4 and WORD_BYTES = 4.
- One sub-module: read_tag_fifo.
  - Synchronous FIFO, parameter DEPTH, data type read_tag_t.
  - Ports: push, pop, head, empty, full.
  - Pointer width $clog2(DEPTH) plus an extra wrap bit.
- Decode, strobe generation and return mux live in mem_router.

Test Plan:
- Write 0x1000_0004, data 0xA5A5_0001, be 4'b0011, slave_ready = 4'hF -> slave_write_req = 4'b0010, slave_addr = 1, ready = 1, no FIFO push.
- Read slave 2 (latency 5), then slave 0 (latency 1) back-to-back -> slave 0's early valid sets error. Repeat with in-order slave valids -> CPU gets slave 2 data, then slave 0 data, each one cycle after its slave valid.
- Issue 4 reads to a slave that withholds valid -> ready = 0 on the 5th cycle. Release one valid -> ready returns to 1 the cycle after the pop.
- Read 0x5000_0000 with NUM_SLAVES = 4 -> no slave strobe; two cycles later read_data = UNMAPPED_DATA, valid = 1. Write to the same address -> no strobe, no error.
- Assert reset with 3 reads outstanding -> next cycle read_data_valid = 0, error = 0, ready = 1. Fresh read completes normally.
- slave_ready[1] = 0 with read to slave 1 -> ready = 0, no strobe. Same cycle, a read to slave 0 is accepted.
